serial_adder_sub: RTL and testbench
===================================

# serial_adder_sub

Bit-serial adder/subtracter for the SAP datapath. It wraps a single full-adder cell with two operand shift registers and a carry flip-flop, and processes one bit per clock, LSB first. It sits between the accumulator/B-register outputs and the W-bus result register. Each operation returns a WIDTH-bit SUM, a CARRY out and a signed OVERFLOW flag after a fixed WIDTH-cycle latency, with a START/BUSY/DONE handshake.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CLK  input  1  system clock, all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request; sampled only when the block is not BUSY.
- SUB  input  1  operation select, sampled with START: 0 = A+B, 1 = A-B.
- A  input  WIDTH  operand A, sampled with START.
- B  input  WIDTH  operand B, sampled with START.
- BUSY  output  1  high while bits are being processed.
- DONE  output  1  one-cycle pulse: result valid and newly updated.
- SUM  output  WIDTH  registered result, held until the next completion.
- CARRY  output  1  carry out of MSB; for SUB, 1 = no borrow (A >= B unsigned).
- OVERFLOW  output  1  signed overflow: carry-in of MSB XOR carry-out of MSB.

## Operation
- Single clock; reset is synchronous and active-high.
- State machine states:
  - IDLE: BUSY=0, DONE=0. START=1 → SHIFT.
  - SHIFT: BUSY=1, DONE=0. Exactly WIDTH cycles, then → FINISH.
  - FINISH: BUSY=0, DONE=1. START=1 → SHIFT (back-to-back); otherwise → IDLE.
- Load on an accepted START:
  - opa ← A.
  - opb ← B XOR {WIDTH{SUB}}.
  - carry flip-flop ← SUB (two's-complement subtract).
  - bit counter ← 0.
  - SUM/CARRY/OVERFLOW outputs are not changed.
- Each SHIFT cycle:
  - Full-adder inputs are opa[0], opb[0] and the carry flip-flop.
  - The sum bit shifts into the MSB of the internal result shift register.
  - opa and opb shift right by one.
  - The carry flip-flop takes the full-adder carry.
  - The counter increments.
- On the last SHIFT cycle (counter = WIDTH-1):
  - SUM ← completed result register, including the final sum bit.
  - CARRY ← final full-adder carry.
  - OVERFLOW ← (carry flip-flop value before the final step) XOR (final carry).
- START while BUSY is ignored; there is no queueing. SUB/A/B are don't-care outside an accepted START.
- Arithmetic is modulo 2^WIDTH. SUM is identical for signed and unsigned interpretations.

## Timing
- Reset values: BUSY=0, DONE=0, SUM=0, CARRY=0, OVERFLOW=0, state=IDLE, internal registers 0.
- START accepted at edge k:
  - BUSY=1 from after edge k through edge k+WIDTH.
  - SUM/CARRY/OVERFLOW update at edge k+WIDTH.
  - DONE=1 for exactly the cycle after edge k+WIDTH, with BUSY=0 in that cycle.
- Latency: WIDTH+1 cycles from START sample to DONE high.
- Back-to-back throughput: one result per WIDTH+1 cycles, with START held or asserted during the DONE cycle.
- Reset asserted mid-operation: at that edge, return to IDLE and clear all outputs to reset values; the partial result is discarded and DONE is not pulsed.
- RST takes priority over START on the same edge.

## Test plan
- WIDTH=8, A=0x3C, B=0x05, SUB=0 → DONE 9 cycles after START; SUM=0x41, CARRY=0, OVERFLOW=0; BUSY high for exactly 8 cycles.
- A=0xFF, B=0x01, SUB=0 → SUM=0x00, CARRY=1, OVERFLOW=0. Then A=0x7F, B=0x01, SUB=0 → SUM=0x80, CARRY=0, OVERFLOW=1.
- Subtract cases:
  - A=0x10, B=0x01, SUB=1 → SUM=0x0F, CARRY=1, OVERFLOW=0.
  - A=0x01, B=0x02, SUB=1 → SUM=0xFF, CARRY=0, OVERFLOW=0.
  - A=0x80, B=0x01, SUB=1 → SUM=0x7F, OVERFLOW=1.
- START pulsed again, with different operands, on cycle 3 of an operation → ignored. The first result completes unchanged and only one DONE pulse occurs.
- START held high continuously with A=0x01, B=0x01, then A=0x02, B=0x02 → DONE pulses exactly 9 cycles apart; SUM=0x02 then SUM=0x04.
- RST for one cycle at SHIFT cycle 4 → the next cycle shows BUSY=0, DONE=0, SUM=0, CARRY=0, OVERFLOW=0. A new START then completes normally.

Source files
------------

// File: rtl/serial_adder_sub.sv
// Bit-serial adder/subtracter: one full-adder cell, two operand shift registers
// and a carry flop, LSB first, WIDTH cycles per result with START/BUSY/DONE.

module sap_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_sub #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SUB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY,
  output logic             OVERFLOW
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa, opb, res;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic             fs, fc;
  logic             last;

  sap_fa u_fa (.a(opa[0]), .b(opb[0]), .ci(cy), .s(fs), .co(fc));

  assign last = (cnt == CW'(WIDTH-1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      opa      <= '0;
      opb      <= '0;
      res      <= '0;
      cy       <= 1'b0;
      cnt      <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      SUM      <= '0;
      CARRY    <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      case (state)
        IDLE, FINISH: begin
          DONE <= 1'b0;
          if (START) begin
            // Subtract as A + ~B + 1: invert B and seed the carry with SUB.
            opa   <= A;
            opb   <= B ^ {WIDTH{SUB}};
            cy    <= SUB;
            cnt   <= '0;
            BUSY  <= 1'b1;
            state <= SHIFT;
          end else begin
            BUSY  <= 1'b0;
            state <= IDLE;
          end
        end
        SHIFT: begin
          res <= {fs, res[WIDTH-1:1]};
          opa <= opa >> 1;
          opb <= opb >> 1;
          cy  <= fc;
          cnt <= cnt + 1'b1;
          if (last) begin
            // cy still holds the carry into the MSB here.
            SUM      <= {fs, res[WIDTH-1:1]};
            CARRY    <= fc;
            OVERFLOW <= cy ^ fc;
            BUSY     <= 1'b0;
            DONE     <= 1'b1;
            state    <= FINISH;
          end
        end
        default: begin
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_sub.sv
// Directed bench for serial_adder_sub with a result scoreboard checked on DONE.

module tb_serial_adder_sub;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST, START, SUB;
  logic [W-1:0] A, B;
  logic         BUSY, DONE, CARRY, OVERFLOW;
  logic [W-1:0] SUM;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
    string        tag;
  } exp_t;

  exp_t sb[$];

  serial_adder_sub #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .START(START), .SUB(SUB), .A(A), .B(B),
    .BUSY(BUSY), .DONE(DONE), .SUM(SUM), .CARRY(CARRY), .OVERFLOW(OVERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input string tag);
    exp_t e;
    logic [W:0] full;
    if (sub) full = {1'b0, a} - {1'b0, b};
    else     full = {1'b0, a} + {1'b0, b};
    e.sum   = full[W-1:0];
    // Unsigned: add carries on wrap; subtract reports 1 when there is no borrow.
    e.carry = sub ? (a >= b) : full[W];
    if (sub) e.ovf = (a[W-1] != b[W-1]) && (e.sum[W-1] != a[W-1]);
    else     e.ovf = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
    e.tag = tag;
    return e;
  endfunction

  always @(negedge CLK) begin
    if (DONE) begin
      exp_t e;
      done_cnt++;
      chk("sb_nonempty_at_done", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({e.tag, "_sum"},   SUM,      e.sum);
        chk({e.tag, "_carry"}, CARRY,    e.carry);
        chk({e.tag, "_ovf"},   OVERFLOW, e.ovf);
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input string tag);
    A = a; B = b; SUB = sub; START = 1'b1;
    sb.push_back(model(a, b, sub, tag));
    @(posedge CLK);
    #1 START = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int n, output int nbusy);
    n = 0; nbusy = 0;
    do begin
      @(negedge CLK);
      n++;
      if (BUSY) nbusy++;
    end while (!DONE && n < 50);
    chk({tag, "_done_seen"}, DONE, 1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input string tag);
    int n, nb;
    issue(a, b, sub, tag);
    wait_done(tag, n, nb);
    chk({tag, "_latency"}, n, W + 1);
    chk({tag, "_busy_cycles"}, nb, W);
    chk({tag, "_done_busy_low"}, BUSY, 0);
    @(negedge CLK);
    chk({tag, "_done_one_cycle"}, DONE, 0);
  endtask

  initial begin
    int n, nb, d0;
    RST = 1'b1; START = 1'b0; SUB = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_sum", SUM, 0);
    chk("rst_carry", CARRY, 0);
    chk("rst_ovf", OVERFLOW, 0);

    run_op(8'h3C, 8'h05, 1'b0, "add_3c_05");
    run_op(8'hFF, 8'h01, 1'b0, "add_ff_01");
    run_op(8'h7F, 8'h01, 1'b0, "add_7f_01");
    run_op(8'h10, 8'h01, 1'b1, "sub_10_01");
    run_op(8'h01, 8'h02, 1'b1, "sub_01_02");
    run_op(8'h80, 8'h01, 1'b1, "sub_80_01");
    run_op(8'hA5, 8'hA5, 1'b1, "sub_eq");

    // START pulsed mid-operation with different operands must be ignored
    d0 = done_cnt;
    issue(8'h22, 8'h11, 1'b0, "ign_first");
    repeat (2) @(posedge CLK);
    #1 A = 8'hFF; B = 8'hFF; SUB = 1'b1; START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    wait_done("ign", n, nb);
    repeat (12) @(negedge CLK);
    chk("ign_single_done", done_cnt - d0, 1);

    // START held high: back-to-back results W+1 cycles apart
    A = 8'h01; B = 8'h01; SUB = 1'b0; START = 1'b1;
    sb.push_back(model(8'h01, 8'h01, 1'b0, "b2b_first"));
    @(posedge CLK);
    #1 A = 8'h02; B = 8'h02;
    sb.push_back(model(8'h02, 8'h02, 1'b0, "b2b_second"));
    wait_done("b2b1", n, nb);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!DONE && n < 50);
    START = 1'b0;
    chk("b2b_done_seen", DONE, 1);
    chk("b2b_gap", n, W + 1);
    repeat (3) @(negedge CLK);
    chk("b2b_idle_busy", BUSY, 0);

    // Reset in the 4th shift cycle discards the operation
    issue(8'h5A, 8'h33, 1'b0, "rst_mid");
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    sb.delete();
    d0 = done_cnt;
    @(negedge CLK);
    chk("rstmid_busy", BUSY, 0);
    chk("rstmid_done", DONE, 0);
    chk("rstmid_sum", SUM, 0);
    chk("rstmid_carry", CARRY, 0);
    chk("rstmid_ovf", OVERFLOW, 0);
    repeat (12) @(negedge CLK);
    chk("rstmid_no_done", done_cnt - d0, 0);

    run_op(8'h5A, 8'h33, 1'b0, "after_rst");
    run_op(8'h00, 8'h00, 1'b1, "sub_zero");

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
